// File: rtl/gf2_pkg.sv
// gf2_pkg: shared FSM encoding and column-index width helper for the GF(2) matrix blocks.
package gf2_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} gfm_state_t;

    function automatic int col_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/gf2_axpy.sv
// gf2_axpy: GF(2) masked accumulate, y = acc ^ (col & {N{b}}).
module gf2_axpy #(
    parameter int N = 32
) (
    input  logic [N-1:0] acc,
    input  logic [N-1:0] col,
    input  logic         b,
    output logic [N-1:0] y
);
    always_comb y = acc ^ (col & {N{b}});
endmodule

// File: rtl/gfm_col_mac.sv
// gfm_col_mac: column-streaming GF(2) matrix-vector multiply y = M*x.
// Define GFM_COLMAC_PARITY_EN to add the res_parity output.
module gfm_col_mac
    import gf2_pkg::*;
#(
    parameter int N = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clk_en,
    input  logic                vec_load,
    input  logic [N-1:0]        vec_in,
    input  logic                clear,
    input  logic                col_valid,
    input  logic [N-1:0]        col_in,
    output logic                col_ready,
    output logic [col_w(N)-1:0] col_idx,
    output logic                res_valid,
    output logic [N-1:0]        res_data,
    input  logic                res_ready,
`ifdef GFM_COLMAC_PARITY_EN
    output logic                res_parity,
`endif
    output logic                busy
);
    localparam int CW = col_w(N);

    gfm_state_t state, nxt;
    logic [N-1:0] x, acc, acc_nxt;
    logic vec_fire, col_fire, res_fire, last;

    always_comb begin
        vec_fire = clk_en && vec_load && state == IDLE;
        col_fire = clk_en && col_valid && col_ready;
        res_fire = clk_en && res_valid && res_ready;
        last     = col_idx == CW'(N - 1);
    end

    gf2_axpy #(.N(N)) u_axpy (
        .acc(acc),
        .col(col_in),
        .b  (x[col_idx]),
        .y  (acc_nxt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nxt;
    end

    // clear outranks every transfer; the final column takes priority over nothing else in ACCUM
    always_comb begin
        nxt = !clk_en            ? state :
              clear              ? IDLE  :
              vec_fire           ? ACCUM :
              (col_fire && last) ? HOLD  :
              res_fire           ? ACCUM : state;
    end

    always_comb begin
        col_ready = state == ACCUM;
        res_valid = state == HOLD;
        busy      = state != IDLE;
`ifdef GFM_COLMAC_PARITY_EN
        res_parity = ^res_data;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x        <= '0;
            acc      <= '0;
            col_idx  <= '0;
            res_data <= '0;
        end else if (clk_en) begin
            if (clear) begin
                acc      <= '0;
                col_idx  <= '0;
                res_data <= '0;
            end else if (vec_fire) begin
                x       <= vec_in;
                acc     <= '0;
                col_idx <= '0;
            end else if (col_fire) begin
                acc     <= last ? '0 : acc_nxt;
                col_idx <= last ? '0 : col_idx + CW'(1);
                if (last) res_data <= acc_nxt;
            end else if (res_fire) begin
                acc <= '0;
            end
        end
    end
endmodule

// File: tb/tb_gfm_col_mac.sv
// tb_gfm_col_mac: table-driven vectors plus directed stall/clear/reset sequences at N=4.
module tb_gfm_col_mac;
    localparam int N = 4;

    logic clk = 0, reset = 0, clk_en = 1, vec_load = 0, clear = 0, col_valid = 0, res_ready = 0;
    logic [N-1:0] vec_in = '0, col_in = '0;
    logic col_ready, res_valid, busy;
    logic [1:0] col_idx;
    logic [N-1:0] res_data;
`ifdef GFM_COLMAC_PARITY_EN
    logic res_parity;
`endif
    int checks = 0, errors = 0;

    typedef struct packed {
        logic [3:0]  x;
        logic [15:0] cols;
        logic [3:0]  y;
    } vec_t;
    vec_t vt[5];

    gfm_col_mac #(.N(N)) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .vec_load(vec_load), .vec_in(vec_in),
        .clear(clear), .col_valid(col_valid), .col_in(col_in), .col_ready(col_ready),
        .col_idx(col_idx), .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
`ifdef GFM_COLMAC_PARITY_EN
        .res_parity(res_parity),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] v);
        clear = 1;
        step();
        clear = 0;
        chk("clear_idle", {31'b0, busy}, 0);
        vec_load = 1;
        vec_in = v;
        step();
        vec_load = 0;
        chk("load_accum", {31'b0, col_ready}, 1);
        chk("load_idx", {30'b0, col_idx}, 0);
    endtask

    // column 0 sits in the low nibble
    task automatic feed(input logic [15:0] cols);
        for (int k = 0; k < 4; k++) begin
            col_valid = 1;
            col_in = cols[4*k +: 4];
            step();
            if (k == 2) chk("no_early_valid", {31'b0, res_valid}, 0);
        end
        col_valid = 0;
    endtask

    task automatic accept();
        res_ready = 1;
        step();
        res_ready = 0;
        chk("accept_valid", {31'b0, res_valid}, 0);
        chk("accept_accum", {31'b0, col_ready}, 1);
    endtask

    initial begin
        vt[0] = {4'b1011, 16'b1000_0100_0010_0001, 4'b1011};
        vt[1] = {4'b0000, 16'b0101_0110_1010_1111, 4'b0000};
        vt[2] = {4'b1111, 16'b1111_0111_0011_0001, 4'b1010};
        vt[3] = {4'b0101, 16'b1111_1010_0011_1100, 4'b0110};
        vt[4] = {4'b1000, 16'b1001_0100_0010_0001, 4'b1001};

        step();
        step();
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_col_ready", {31'b0, col_ready}, 0);
        chk("rst_res_valid", {31'b0, res_valid}, 0);
        chk("rst_res_data", {28'b0, res_data}, 0);
        chk("rst_col_idx", {30'b0, col_idx}, 0);
        reset = 1;
        step();
        chk("idle_ready", {31'b0, col_ready}, 0);

        for (int i = 0; i < 5; i++) begin
            load(vt[i].x);
            feed(vt[i].cols);
            chk("res_valid", {31'b0, res_valid}, 1);
            chk("res_data", {28'b0, res_data}, {28'b0, vt[i].y});
            chk("hold_ready", {31'b0, col_ready}, 0);
            chk("wrap_idx", {30'b0, col_idx}, 0);
`ifdef GFM_COLMAC_PARITY_EN
            chk("parity", {31'b0, res_parity}, {31'b0, ^vt[i].y});
`endif
            accept();
        end

        // backpressure, vec_load ignored outside IDLE, then streaming with retained x
        load(4'b1011);
        vec_load = 1;
        vec_in = 4'b0000;
        step();
        vec_load = 0;
        feed(16'h8421);
        chk("seqa_res", {28'b0, res_data}, 32'hb);
        col_valid = 1;
        col_in = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("stall_data", {28'b0, res_data}, 32'hb);
            chk("stall_ready", {31'b0, col_ready}, 0);
            chk("stall_valid", {31'b0, res_valid}, 1);
        end
        col_valid = 0;
        accept();
        feed(16'hffff);
        chk("ones_res", {28'b0, res_data}, 32'hf);
`ifdef GFM_COLMAC_PARITY_EN
        chk("ones_parity", {31'b0, res_parity}, 0);
`endif
        accept();

        // clk_en low freezes everything mid-matrix and in HOLD
        col_valid = 1;
        col_in = 4'b0001;
        step();
        col_in = 4'b0010;
        step();
        clk_en = 0;
        col_in = 4'b0100;
        repeat (3) step();
        chk("gated_idx", {30'b0, col_idx}, 2);
        chk("gated_ready", {31'b0, col_ready}, 1);
        clk_en = 1;
        step();
        col_in = 4'b1000;
        step();
        col_valid = 0;
        chk("gated_res_valid", {31'b0, res_valid}, 1);
        chk("gated_res", {28'b0, res_data}, 32'hb);
        clk_en = 0;
        res_ready = 1;
        step();
        chk("gated_hold", {31'b0, res_valid}, 1);
        clk_en = 1;
        step();
        res_ready = 0;
        chk("gated_accept", {31'b0, res_valid}, 0);

        // clear beats a simultaneous column transfer
        col_valid = 1;
        col_in = 4'b0001;
        step();
        col_in = 4'b0010;
        step();
        clear = 1;
        col_in = 4'b0100;
        step();
        clear = 0;
        col_valid = 0;
        chk("clr_busy", {31'b0, busy}, 0);
        chk("clr_ready", {31'b0, col_ready}, 0);
        chk("clr_idx", {30'b0, col_idx}, 0);

        // async reset in HOLD acts without a clock edge
        load(4'b1011);
        feed(16'h8421);
        chk("pre_rst_valid", {31'b0, res_valid}, 1);
        #2;
        reset = 0;
        #1;
        chk("async_valid", {31'b0, res_valid}, 0);
        chk("async_data", {28'b0, res_data}, 0);
        chk("async_busy", {31'b0, busy}, 0);
        chk("async_ready", {31'b0, col_ready}, 0);
        step();
        reset = 1;
        step();
        chk("post_rst_idle", {31'b0, busy}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gfm_col_mac.md
GFM_COL_MAC -- requirements
Module: gfm_col_mac

Interface
REQ-001 SHALL have parameter: N, 32, matrix dimension and width of column, vector and result.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: clk_en  input  1  global enable; no transfer or state change while low.
REQ-005 SHALL have port: vec_load  input  1  load multiplicand vector.
REQ-006 SHALL have port: vec_in  input  N  GF(2) vector x.
REQ-007 SHALL have port: clear  input  1  synchronous abort of the current product.
REQ-008 SHALL have port: col_valid  input  1  col_in holds a matrix column (fed from the transposer's column-wise output).
REQ-009 SHALL have port: col_in  input  N  matrix column k, with k = current col_idx.
REQ-010 SHALL have port: col_ready  output  1  block accepts a column this cycle.
REQ-011 SHALL have port: col_idx  output  clog2(N)  index of the next column expected.
REQ-012 SHALL have port: res_valid  output  1  res_data holds a completed product.
REQ-013 SHALL have port: res_data  output  N  y = M·x over GF(2).
REQ-014 SHALL have port: res_ready  input  1  consumer accepts the result.
REQ-015 SHALL have port: busy  output  1  state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, ACCUM and HOLD.
REQ-017 A transfer SHALL occur only when clk_en=1: vector when vec_load=1 in IDLE, column when col_valid=1 and col_ready=1, result when res_valid=1 and res_ready=1.
REQ-018 SHALL, in IDLE: col_ready=0 and res_valid=0; vec_load captures x, clears acc and col_idx, and moves to ACCUM; vec_load is ignored in every other state.
REQ-019 SHALL, in ACCUM: col_ready=1; each column transfer performs acc <= acc XOR (col_in AND {N{x[col_idx]}}) and col_idx <= col_idx+1.
REQ-020 SHALL, on the transfer with col_idx=N-1: load res_data with the final acc value, wrap col_idx to 0 and enter HOLD; res_valid SHALL rise the next cycle (latency = 1 cycle after the Nth column).
REQ-021 SHALL, in HOLD: res_valid=1 and col_ready=0, with res_data stable until the result transfer.
REQ-022 SHALL, on the result transfer: return to ACCUM with acc cleared and x retained, so back-to-back matrices stream with the same vector.
REQ-023 clear with clk_en=1 SHALL force IDLE from any state, zero acc and col_idx, and discard any pending result; clear SHALL take priority over simultaneous column or result transfers.
REQ-024 While clk_en=0, all registers SHALL hold; outputs SHALL still reflect the held state.
REQ-025 All arithmetic SHALL be GF(2): XOR/AND only, with no carries.

Reset
REQ-026 With reset low, the block SHALL immediately enter IDLE with acc=0, x=0, col_idx=0, res_data=0, res_valid=0, col_ready=0 and busy=0, including when reset is asserted mid-ACCUM or mid-HOLD.

Configuration
REQ-027 With macro GFM_COLMAC_PARITY_EN defined, the block SHALL add output res_parity (1 bit), equal to the XOR of res_data bits and valid with res_valid; without the macro, the port and its logic SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-028 The FSM state encoding and the column-index width function SHALL reside in shared package gf2_pkg.
REQ-029 The AND-mask/XOR update SHALL be a sub-module gf2_axpy (N-bit acc ^ (col & {N{b}})); everything else SHALL be flat.

Verification (N=4)
REQ-030 SHALL test: x=1011, columns 0001,0010,0100,1000 -> res_data=1011, res_valid high exactly 1 cycle after the 4th column.
REQ-031 SHALL test: x=0000, any 4 columns -> res_data=0000.
REQ-032 SHALL test: hold res_ready=0 for 5 cycles -> res_data stable and col_ready=0; then accept -> ACCUM; next matrix of all-1111 columns -> res_data=1111.
REQ-033 SHALL test: clk_en=0 after 2 columns with col_valid=1 -> col_idx stays 2 and acc is unchanged; re-enable -> completion is correct.
REQ-034 SHALL test: clear after 2 columns -> IDLE and col_ready=0; reset asserted during HOLD -> res_valid drops with no clock edge.
REQ-035 SHALL test, with GFM_COLMAC_PARITY_EN defined: res_data=1011 -> res_parity=1; res_data=1111 -> res_parity=0.
